// File: rtl/leaf_mport_adapter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// leaf_mport_adapter : multi-port BFT leaf adapter with RX FIFOs, TX arbitration
// Revision 1.0
// ---------------------------------------------------------------------------
module leaf_mport_adapter #(
   parameter int PACKET_BITS   = 49,
   parameter int PAYLOAD_BITS  = 32,
   parameter int NUM_LEAF_BITS = 3,
   parameter int NUM_PORT_BITS = 4,
   parameter int SEQ_BITS      = 9,
   parameter int LEAF_ID       = 4,
   parameter int NUM_IN_PORTS  = 2,
   parameter int NUM_OUT_PORTS = 2,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic [PACKET_BITS-1:0]                         din_leaf_bft2interface,
   output logic [PACKET_BITS-1:0]                         dout_leaf_interface2bft,
   input  logic                                           tx_stall,
   input  logic                                           clear_flags,
   input  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg,
   output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]           dout_leaf_interface2user,
   output logic [NUM_IN_PORTS-1:0]                        vld_interface2user,
   input  logic [NUM_IN_PORTS-1:0]                        ack_user2interface,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]          din_leaf_user2interface,
   input  logic [NUM_OUT_PORTS-1:0]                       vld_user2interface,
   output logic [NUM_OUT_PORTS-1:0]                       ack_interface2user,
   output logic [NUM_IN_PORTS-1:0]                        rx_overflow,
   output logic                                           rx_misroute
);

   localparam int DW       = NUM_LEAF_BITS + NUM_PORT_BITS;
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int GW       = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
   localparam int SEQ_LSB  = PAYLOAD_BITS;
   localparam int PORT_LSB = PAYLOAD_BITS + SEQ_BITS;
   localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;

   // ------------------------------------------------------------------ RX
   logic                     pkt_valid;
   logic [NUM_LEAF_BITS-1:0] pkt_leaf;
   logic [NUM_PORT_BITS-1:0] pkt_port;
   logic [PAYLOAD_BITS-1:0]  pkt_payload;
   logic                     addr_ok;
   logic                     rx_accept;
   logic                     misroute_set;
   logic [NUM_IN_PORTS-1:0]  ovf_set;
   logic                     unused_seq_bits;

   assign pkt_valid    = din_leaf_bft2interface[PACKET_BITS-1];
   assign pkt_leaf     = din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS];
   assign pkt_port     = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
   assign pkt_payload  = din_leaf_bft2interface[PAYLOAD_BITS-1:0];
   assign unused_seq_bits = ^din_leaf_bft2interface[SEQ_LSB +: SEQ_BITS];

   assign addr_ok      = (pkt_leaf == NUM_LEAF_BITS'(LEAF_ID)) &&
                         (32'(pkt_port) < NUM_IN_PORTS);
   assign rx_accept    = pkt_valid && addr_ok;
   assign misroute_set = pkt_valid && !addr_ok;

   generate
      for (genvar p = 0; p < NUM_IN_PORTS; p++) begin : g_rx_port
         logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
         logic [AW-1:0]           wr_ptr;
         logic [AW-1:0]           rd_ptr;
         logic [AW:0]             count;
         logic                    wr_req;
         logic                    pop;
         logic                    full;
         logic                    wr_ok;

         assign wr_req = rx_accept && (32'(pkt_port) == p);
         assign pop    = (count != '0) && ack_user2interface[p];
         assign full   = (count == (AW+1)'(FIFO_DEPTH));
         // A same-cycle pop frees the slot the write needs.
         assign wr_ok  = wr_req && (!full || pop);
         assign ovf_set[p] = wr_req && full && !pop;

         always_ff @(posedge clk) begin
            if (wr_ok) begin
               mem[wr_ptr] <= pkt_payload;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               count  <= '0;
            end else begin
               if (wr_ok) begin
                  wr_ptr <= wr_ptr + AW'(1);
               end
               if (pop) begin
                  rd_ptr <= rd_ptr + AW'(1);
               end
               case ({wr_ok, pop})
                  2'b10:   count <= count + (AW+1)'(1);
                  2'b01:   count <= count - (AW+1)'(1);
                  default: count <= count;
               endcase
            end
         end

         assign dout_leaf_interface2user[p*PAYLOAD_BITS +: PAYLOAD_BITS] = mem[rd_ptr];
         assign vld_interface2user[p] = (count != '0);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_overflow <= '0;
         rx_misroute <= 1'b0;
      end else if (clear_flags) begin
         rx_overflow <= ovf_set;
         rx_misroute <= misroute_set;
      end else begin
         rx_overflow <= rx_overflow | ovf_set;
         rx_misroute <= rx_misroute | misroute_set;
      end
   end

   // ------------------------------------------------------------------ TX
   logic [GW-1:0]       last_grant;
   logic [GW-1:0]       grant_idx;
   logic [GW-1:0]       cand;
   logic                grant_any;
   logic [SEQ_BITS-1:0] seq_cnt [NUM_OUT_PORTS];

   // Search starts one past the previous winner so every requester gets a turn.
   always_comb begin
      grant_any          = 1'b0;
      grant_idx          = '0;
      cand               = '0;
      ack_interface2user = '0;
      if (!reset && !tx_stall) begin
         for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_OUT_PORTS);
            if (!grant_any && vld_user2interface[cand]) begin
               grant_any = 1'b1;
               grant_idx = cand;
            end
         end
      end
      if (grant_any) begin
         ack_interface2user[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dout_leaf_interface2bft <= '0;
         last_grant              <= GW'(NUM_OUT_PORTS - 1);
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            seq_cnt[i] <= '0;
         end
      end else if (grant_any) begin
         dout_leaf_interface2bft <= {1'b1,
                                     dest_cfg[grant_idx*DW +: DW],
                                     seq_cnt[grant_idx],
                                     din_leaf_user2interface[grant_idx*PAYLOAD_BITS +: PAYLOAD_BITS]};
         seq_cnt[grant_idx]      <= seq_cnt[grant_idx] + SEQ_BITS'(1);
         last_grant              <= grant_idx;
      end else begin
         dout_leaf_interface2bft <= '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_leaf_mport_adapter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_leaf_mport_adapter : vector table, directed sequences and random model check
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_leaf_mport_adapter;

   localparam int PB = 49;

   logic          clk = 1'b0;
   logic          reset;
   logic [PB-1:0] din_bft;
   logic [PB-1:0] dout_bft;
   logic          tx_stall;
   logic          clear_flags;
   logic [13:0]   dest_cfg;
   logic [63:0]   dout_user;
   logic [1:0]    vld_i2u;
   logic [1:0]    ack_u2i;
   logic [63:0]   din_user;
   logic [1:0]    vld_u2i;
   logic [1:0]    ack_i2u;
   logic [1:0]    rx_overflow;
   logic          rx_misroute;

   always #5 clk = ~clk;

   leaf_mport_adapter #(
      .PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(3), .NUM_PORT_BITS(4),
      .SEQ_BITS(9), .LEAF_ID(4), .NUM_IN_PORTS(2), .NUM_OUT_PORTS(2), .FIFO_DEPTH(8)
   ) dut (
      .clk(clk), .reset(reset),
      .din_leaf_bft2interface(din_bft), .dout_leaf_interface2bft(dout_bft),
      .tx_stall(tx_stall), .clear_flags(clear_flags), .dest_cfg(dest_cfg),
      .dout_leaf_interface2user(dout_user), .vld_interface2user(vld_i2u),
      .ack_user2interface(ack_u2i), .din_leaf_user2interface(din_user),
      .vld_user2interface(vld_u2i), .ack_interface2user(ack_i2u),
      .rx_overflow(rx_overflow), .rx_misroute(rx_misroute)
   );

   // Reference model
   logic [31:0] rxq [2][$];
   logic [1:0]  m_ovf;
   logic        m_mis;
   int          m_last;
   int          m_seq [2];
   logic [48:0] m_dout;
   int          m_g;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [48:0] mkpkt(input bit v, input int leaf, input int port,
                                         input logic [31:0] pl);
      return {v, 3'(leaf), 4'(port), 9'd0, pl};
   endfunction

   function automatic int model_grant();
      if (reset || tx_stall) return -1;
      for (int k = 1; k <= 2; k++) begin
         int i;
         i = (m_last + k) % 2;
         if (vld_u2i[i]) return i;
      end
      return -1;
   endfunction

   task automatic cycle();
      int         g;
      logic [1:0] oset;
      logic       mset;
      logic [2:0] leaf;
      logic [3:0] port;
      #1;
      g   = model_grant();
      m_g = g;
      chk("tx_ack", 64'(ack_i2u), (g < 0) ? 64'd0 : 64'(1 << g));
      @(posedge clk);
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            rxq[p].delete();
            m_seq[p] = 0;
         end
         m_ovf  = '0;
         m_mis  = 1'b0;
         m_last = 1;
         m_dout = '0;
      end else begin
         for (int p = 0; p < 2; p++)
            if (rxq[p].size() > 0 && ack_u2i[p]) void'(rxq[p].pop_front());
         oset = '0;
         mset = 1'b0;
         if (din_bft[48]) begin
            leaf = din_bft[47:45];
            port = din_bft[44:41];
            if (leaf == 3'd4 && port < 4'd2) begin
               if (rxq[port].size() < 8) rxq[port].push_back(din_bft[31:0]);
               else oset[port] = 1'b1;
            end else begin
               mset = 1'b1;
            end
         end
         m_ovf = clear_flags ? oset : (m_ovf | oset);
         m_mis = clear_flags ? mset : (m_mis | mset);
         if (g >= 0) begin
            m_dout   = {1'b1, dest_cfg[g*7 +: 7], 9'(m_seq[g]), din_user[g*32 +: 32]};
            m_seq[g] = (m_seq[g] + 1) % 512;
            m_last   = g;
         end else begin
            m_dout = '0;
         end
      end
      #1;
      for (int p = 0; p < 2; p++) begin
         chk("rx_vld", 64'(vld_i2u[p]), 64'(rxq[p].size() > 0));
         if (rxq[p].size() > 0) chk("rx_data", 64'(dout_user[p*32 +: 32]), 64'(rxq[p][0]));
      end
      chk("tx_dout", 64'(dout_bft), 64'(m_dout));
      chk("rx_overflow", 64'(rx_overflow), 64'(m_ovf));
      chk("rx_misroute", 64'(rx_misroute), 64'(m_mis));
   endtask

   typedef struct {
      logic [48:0] pkt;
      logic [1:0]  ack;
      logic        clr;
      logic [1:0]  exp_vld;
      logic        exp_mis;
      logic [31:0] exp_d1;
   } vec_t;

   vec_t vt [8];

   initial begin
      vt[0] = '{mkpkt(1, 4, 1, 32'hDEADBEEF), 2'b00, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF};
      vt[1] = '{49'd0,                        2'b10, 1'b0, 2'b00, 1'b0, 32'h0};
      vt[2] = '{mkpkt(1, 3, 0, 32'h1),        2'b00, 1'b0, 2'b00, 1'b1, 32'h0};
      vt[3] = '{mkpkt(1, 4, 5, 32'h2),        2'b00, 1'b0, 2'b00, 1'b1, 32'h0};
      vt[4] = '{49'd0,                        2'b00, 1'b1, 2'b00, 1'b0, 32'h0};
      vt[5] = '{mkpkt(0, 4, 0, 32'h3),        2'b00, 1'b0, 2'b00, 1'b0, 32'h0};
      vt[6] = '{mkpkt(1, 4, 0, 32'h11),       2'b00, 1'b0, 2'b01, 1'b0, 32'h0};
      vt[7] = '{49'd0,                        2'b11, 1'b0, 2'b00, 1'b0, 32'h0};

      reset = 1'b1; din_bft = '0; tx_stall = 1'b0; clear_flags = 1'b0;
      ack_u2i = '0; din_user = '0; vld_u2i = '0;
      dest_cfg = {7'h57, 7'h23};   // port1 -> leaf5/port7, port0 -> leaf2/port3
      m_g = -1;
      repeat (3) cycle();
      chk("reset_vld", 64'(vld_i2u), 64'd0);
      chk("reset_dout", 64'(dout_bft), 64'd0);
      reset = 1'b0;

      // Table-driven RX basic / misroute / clear
      foreach (vt[i]) begin
         din_bft = vt[i].pkt; ack_u2i = vt[i].ack; clear_flags = vt[i].clr;
         cycle();
         chk("tbl_vld", 64'(vld_i2u), 64'(vt[i].exp_vld));
         chk("tbl_mis", 64'(rx_misroute), 64'(vt[i].exp_mis));
         if (vt[i].exp_vld[1]) chk("tbl_d1", 64'(dout_user[63:32]), 64'(vt[i].exp_d1));
      end
      din_bft = '0; ack_u2i = '0; clear_flags = 1'b0;

      // Overflow: 9 writes to port 0
      for (int i = 1; i <= 9; i++) begin
         din_bft = mkpkt(1, 4, 0, 32'(i));
         cycle();
      end
      din_bft = '0;
      chk("ovf_flag", 64'(rx_overflow[0]), 64'd1);
      chk("ovf_head", 64'(dout_user[31:0]), 64'd1);
      clear_flags = 1'b1;
      cycle();
      clear_flags = 1'b0;
      chk("ovf_clear", 64'(rx_overflow), 64'd0);

      // Full FIFO: write plus pop in the same cycle is accepted
      din_bft = mkpkt(1, 4, 0, 32'd100);
      ack_u2i = 2'b01;
      cycle();
      din_bft = '0;
      ack_u2i = '0;
      chk("fullpop_ovf", 64'(rx_overflow[0]), 64'd0);
      chk("fullpop_head", 64'(dout_user[31:0]), 64'd2);
      for (int k = 0; k < 8; k++) begin
         chk("drain_head", 64'(dout_user[31:0]), (k < 7) ? 64'(k + 2) : 64'd100);
         ack_u2i = 2'b01;
         cycle();
      end
      ack_u2i = '0;
      chk("drain_empty", 64'(vld_i2u[0]), 64'd0);

      // TX round robin
      din_user = {32'hB0, 32'hA0};
      vld_u2i  = 2'b11;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("rr_dout", 64'(dout_bft),
             (i % 2 == 0) ? 64'({1'b1, 7'h23, 9'(i / 2), 32'hA0})
                          : 64'({1'b1, 7'h57, 9'(i / 2), 32'hB0}));
      end

      // Stall
      tx_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_ack", 64'(ack_i2u), 64'd0);
         cycle();
         chk("stall_dout", 64'(dout_bft[48]), 64'd0);
      end
      tx_stall = 1'b0;

      // Reset mid-operation with requests pending and data in a FIFO
      din_bft = mkpkt(1, 4, 1, 32'h55);
      cycle();
      din_bft = '0;
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      chk("rst_mid_vld", 64'(vld_i2u), 64'd0);
      chk("rst_mid_dout", 64'(dout_bft), 64'd0);

      // Sequence wrap on port 0
      vld_u2i = 2'b01;
      for (int i = 0; i <= 512; i++) begin
         din_user[31:0] = 32'(i);
         cycle();
         chk("seq_wrap", 64'(dout_bft[40:32]), 64'(i % 512));
      end
      vld_u2i = '0;

      // Random traffic; user side holds vld/data until acknowledged
      for (int c = 0; c < 3000; c++) begin
         reset       = ($urandom_range(0, 299) == 0);
         tx_stall    = ($urandom_range(0, 4) == 0);
         clear_flags = ($urandom_range(0, 19) == 0);
         ack_u2i     = 2'($urandom);
         din_bft     = mkpkt($urandom_range(0, 3) != 0,
                             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 4,
                             $urandom_range(0, 2), $urandom);
         for (int p = 0; p < 2; p++) begin
            if (!vld_u2i[p] || m_g == p) begin
               vld_u2i[p] = $urandom_range(0, 1) == 1;
               din_user[p*32 +: 32] = $urandom;
            end
         end
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
